// File: rtl/shadow_capture_mc_if.sv
// shadow_capture_mc_if: capture, error-injection and per-chain dump signals of shadow_capture_mc.
interface shadow_capture_mc_if #(
  parameter int DFF_BITS = 282,
  parameter int CHAINS = 2,
  parameter int ERR_W = 9
);
  logic c_en;
  logic [DFF_BITS-1:0] din;
  logic err_en;
  logic [ERR_W-1:0] err_ctrl;
  logic [CHAINS-1:0] dump_en;
  logic [CHAINS-1:0] ch_out;
  logic [CHAINS-1:0] ch_out_vld;
  logic [CHAINS-1:0] ch_out_done;
  logic busy;
  modport master (output c_en, din, err_en, err_ctrl, dump_en, input ch_out, ch_out_vld, ch_out_done, busy);
  modport slave (input c_en, din, err_en, err_ctrl, dump_en, output ch_out, ch_out_vld, ch_out_done, busy);
endinterface

// File: rtl/shadow_capture_mc.sv
// shadow_capture_mc: snapshots a state vector into shadow flops and dumps it over CHAINS
// independent serial chains, with single-bit error injection and optional one-shot capture.
module shadow_capture_mc #(
  parameter int DFF_BITS = 282,
  parameter int CHAINS = 2,
  parameter bit ONE_SHOT = 1'b0,
  parameter int ERR_W = 9
) (
  input logic sh_clk,
  input logic sh_rst_l,
  shadow_capture_mc_if.slave bus
);
  localparam int L = (DFF_BITS + CHAINS - 1) / CHAINS;
  localparam int CW = $clog2(L + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  logic [DFF_BITS-1:0] snap;
  logic [DFF_BITS-1:0] inj;
  logic [CHAINS*L-1:0] pad;
  logic [CHAINS-1:0] act;
  logic [CHAINS-1:0] fin;
  logic frozen;
  logic cap;
  assign bus.busy = |act;
  assign cap = bus.c_en && !bus.busy && !frozen;
  assign inj = (bus.err_en && 32'(bus.err_ctrl) < DFF_BITS) ? DFF_BITS'(1'b1) << bus.err_ctrl : '0;
  // last chain is zero-padded past DFF_BITS
  assign pad = (CHAINS*L)'(snap);
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      snap <= '0;
      frozen <= 1'b0;
    end else begin
      snap <= (cap ? bus.din : snap) ^ inj;
      frozen <= (ONE_SHOT && cap) || (frozen && !(|fin));
    end
  end
  for (genvar i = 0; i < CHAINS; i++) begin : g_ch
    state_t st, nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [L-1:0] bits;
    assign bits = pad[i*L +: L] >> cnt;
    always_ff @(posedge sh_clk or negedge sh_rst_l) begin
      if (!sh_rst_l) begin
        st <= IDLE;
        cnt <= '0;
      end else begin
        st <= nx;
        cnt <= cnt_nx;
      end
    end
    always_comb begin
      nx = st == IDLE ? (bus.dump_en[i] ? SHIFT : IDLE) : st == SHIFT ? (cnt == CW'(L - 1) ? DONE : SHIFT) : IDLE;
      cnt_nx = st == SHIFT ? cnt + CW'(1) : '0;
    end
    assign act[i] = st != IDLE;
    assign fin[i] = st == DONE;
    assign bus.ch_out_vld[i] = st == SHIFT;
    assign bus.ch_out[i] = st == SHIFT && bits[0];
    assign bus.ch_out_done[i] = fin[i];
  end
endmodule

// File: tb/tb_shadow_capture_mc.sv
// tb_shadow_capture_mc: directed checks of three shadow_capture_mc configurations
// (10/2, 9/2 and 10/2 one-shot) against a bench-side snapshot model and output queue.
module tb_shadow_capture_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int sel = 0;
  logic c_en = 1'b0;
  logic [9:0] din = '0;
  logic err_en = 1'b0;
  logic [3:0] err_ctrl = '0;
  logic [1:0] dump_en = '0;
  logic [1:0] out, vld, done;
  logic busy;
  logic [9:0] m_snap [3];
  bit m_frz = 1'b0;
  logic [1:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  shadow_capture_mc_if #(.DFF_BITS(10), .CHAINS(2), .ERR_W(4)) ia ();
  shadow_capture_mc_if #(.DFF_BITS(9), .CHAINS(2), .ERR_W(4)) ib ();
  shadow_capture_mc_if #(.DFF_BITS(10), .CHAINS(2), .ERR_W(4)) ic ();
  shadow_capture_mc #(.DFF_BITS(10), .CHAINS(2), .ONE_SHOT(1'b0), .ERR_W(4)) dut_a (.sh_clk(clk), .sh_rst_l(rst_n), .bus(ia));
  shadow_capture_mc #(.DFF_BITS(9), .CHAINS(2), .ONE_SHOT(1'b0), .ERR_W(4)) dut_b (.sh_clk(clk), .sh_rst_l(rst_n), .bus(ib));
  shadow_capture_mc #(.DFF_BITS(10), .CHAINS(2), .ONE_SHOT(1'b1), .ERR_W(4)) dut_c (.sh_clk(clk), .sh_rst_l(rst_n), .bus(ic));
  assign ia.c_en = sel == 0 && c_en;
  assign ib.c_en = sel == 1 && c_en;
  assign ic.c_en = sel == 2 && c_en;
  assign ia.din = din;
  assign ib.din = din[8:0];
  assign ic.din = din;
  assign ia.err_en = sel == 0 && err_en;
  assign ib.err_en = sel == 1 && err_en;
  assign ic.err_en = sel == 2 && err_en;
  assign ia.err_ctrl = err_ctrl;
  assign ib.err_ctrl = err_ctrl;
  assign ic.err_ctrl = err_ctrl;
  assign ia.dump_en = sel == 0 ? dump_en : 2'b00;
  assign ib.dump_en = sel == 1 ? dump_en : 2'b00;
  assign ic.dump_en = sel == 2 ? dump_en : 2'b00;
  always_comb begin
    out = sel == 0 ? ia.ch_out : sel == 1 ? ib.ch_out : ic.ch_out;
    vld = sel == 0 ? ia.ch_out_vld : sel == 1 ? ib.ch_out_vld : ic.ch_out_vld;
    done = sel == 0 ? ia.ch_out_done : sel == 1 ? ib.ch_out_done : ic.ch_out_done;
    busy = sel == 0 ? ia.busy : sel == 1 ? ib.busy : ic.busy;
  end
  function automatic int nb();
    return sel == 1 ? 9 : 10;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask
  // one clock with the given inputs; the model applies capture/injection as the DUT should
  task automatic cyc(input logic ce, input logic [9:0] d, input logic ee, input logic [3:0] ec);
    logic [9:0] nxt;
    logic cap;
    c_en = ce; din = d; err_en = ee; err_ctrl = ec;
    cap = ce && !(sel == 2 && m_frz);
    nxt = cap ? d : m_snap[sel];
    if (ee && int'(ec) < nb()) nxt[ec] = ~nxt[ec];
    if (sel == 1) nxt[9] = 1'b0;
    if (cap && sel == 2) m_frz = 1'b1;
    m_snap[sel] = nxt;
    @(posedge clk); #1;
    c_en = 1'b0; err_en = 1'b0; err_ctrl = '0;
  endtask
  task automatic dump(input logic [1:0] m, input logic ce, input logic [9:0] d);
    logic [1:0] e;
    for (int k = 0; k < 5; k++) begin
      e = '0;
      for (int c = 0; c < 2; c++) if (m[c] && c*5 + k < nb()) e[c] = m_snap[sel][c*5 + k];
      q.push_back(e);
    end
    dump_en = m;
    @(posedge clk); #1;
    dump_en = '0; c_en = ce; din = d;
    for (int k = 0; k < 5; k++) begin
      chk("vld", 32'(vld), 32'(m));
      chk("out", 32'(out), 32'(q.pop_front()));
      chk("done_early", 32'(done), 0);
      chk("busy_shift", 32'(busy), 1);
      @(posedge clk); #1;
    end
    chk("done_pulse", 32'(done), 32'(m));
    chk("vld_in_done", 32'(vld), 0);
    chk("out_in_done", 32'(out), 0);
    chk("busy_done", 32'(busy), 1);
    c_en = 1'b0;
    @(posedge clk); #1;
    chk("done_after", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    if (sel == 2) m_frz = 1'b0;
  endtask
  initial begin
    for (int s = 0; s < 3; s++) m_snap[s] = '0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_out", 32'({out, vld, done}), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    sel = 0;
    cyc(1, 10'h2B5, 0, 0);
    dump(2'b01, 0, 0);
    cyc(1, 10'h3FF, 0, 0);
    dump(2'b11, 0, 0);
    dump(2'b01, 0, 0);
    sel = 1;
    cyc(1, 10'h1FF, 0, 0);
    dump(2'b10, 0, 0);
    sel = 0;
    cyc(1, 10'h000, 0, 0);
    cyc(0, 10'h000, 1, 4'd7);
    dump(2'b10, 0, 0);
    cyc(0, 10'h000, 1, 4'd12);
    dump(2'b11, 0, 0);
    cyc(1, 10'h001, 1, 4'd0);
    dump(2'b11, 1, 10'h155);
    dump(2'b11, 0, 0);
    sel = 2;
    cyc(1, 10'h155, 0, 0);
    cyc(1, 10'h0AA, 0, 0);
    cyc(1, 10'h0AA, 0, 0);
    dump(2'b11, 1, 10'h0AA);
    cyc(1, 10'h0AA, 0, 0);
    dump(2'b11, 0, 0);
    sel = 0;
    cyc(1, 10'h3FF, 0, 0);
    dump_en = 2'b01;
    @(posedge clk); #1;
    dump_en = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_vld", 32'(vld), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'({out, vld}), 0);
    chk("arst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("arst_nodone", 32'(done), 0);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) m_snap[s] = '0;
    m_frz = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(done), 0);
    dump(2'b11, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
